// File: rtl/bus_dma_pkg.sv
// Shared definitions for the bus DMA engine: io map constants and FSM state encoding.
package bus_dma_pkg;

    localparam logic [15:0] GPI_A  = 16'h0100;
    localparam logic [15:0] GPO_A  = 16'h0101;
    localparam int unsigned RAM_AW = 7;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StRd   = 3'd2,
        StWr   = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/bus_dma.sv
// Bus-initiator DMA: copies or fills a block of words over the io bus while granted.
// Copy does a read/write pair per word; fill writes one word per granted cycle.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_fill,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_pattern,
    output logic          done,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_dout,
    output logic          bus_we,
    input  logic [DW-1:0] bus_din
);

    state_e        state_q, state_d;
    logic          fill_q, fill_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [DW-1:0] pattern_q, pattern_d;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        pattern_d = pattern_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_dout  = '0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    fill_d    = cmd_fill;
                    src_d     = cmd_src;
                    dst_d     = cmd_dst;
                    len_d     = cmd_len;
                    pattern_d = cmd_pattern;
                    state_d   = (cmd_len == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = fill_q ? StWr : StRd;
                end
            end
            StRd: begin
                bus_req  = 1'b1;
                bus_addr = src_q;
                state_d  = bus_gnt ? StWr : StReq;
            end
            StWr: begin
                bus_req  = 1'b1;
                bus_addr = dst_q;
                // Slave holds the read data through write cycles, so bus_din is still valid here.
                bus_dout = fill_q ? pattern_q : bus_din;
                if (bus_gnt) begin
                    bus_we = 1'b1;
                    src_d  = src_q + AW'(1);
                    dst_d  = dst_q + AW'(1);
                    len_d  = len_q - AW'(1);
                    if (len_q == AW'(1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = fill_q ? StWr : StRd;
                    end
                end else begin
                    state_d = StReq;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A reset landing mid-word must not let the in-flight write or a done pulse escape.
        if (rst) begin
            bus_we = 1'b0;
            done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            fill_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            pattern_q <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            pattern_q <= pattern_d;
        end
    end

endmodule
